// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control sequencer: IF/ID/EXE/MEM/WB strobes over a shared memory port with ready handshake.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state; otherwise they execute as NOPs.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       PCWr,
  output logic [1:0] PCSrc,
  output logic       IRWr,
  output logic       IorD,
  output logic       MemR,
  output logic       MemW,
  output logic       Mem2R,
  output logic       RegDst,
  output logic       RegW,
  output logic       Alusrc,
  output logic [1:0] ExtOp,
  output logic [1:0] Aluctrl,
  output logic [2:0] state,
  output logic       mem_err,
  output logic       illegal
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d, fn_q, fn_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ill_q, ill_d;
  logic       pcwr, irwr, iord, memr, memw, mem2r, regdst, regw, alusrc, merr;
  logic [1:0] pcsrc, extop, aluctrl;
  logic       id_legal, tmo;

  assign id_legal = (OpCode == OP_R && (funct == FN_ADDU || funct == FN_SUBU)) ||
                    OpCode == OP_ORI || OpCode == OP_LUI || OpCode == OP_LW ||
                    OpCode == OP_SW  || OpCode == OP_BEQ;
  // A ready arriving on the last allowed cycle wins over the timeout.
  assign tmo = (cnt_q == CNT_LAST) && !mem_rdy;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    cnt_d   = '0;
    ill_d   = ill_q;
    pcwr = 1'b0; irwr = 1'b0; iord = 1'b0; memr = 1'b0; memw = 1'b0;
    mem2r = 1'b0; regdst = 1'b0; regw = 1'b0; alusrc = 1'b0; merr = 1'b0;
    pcsrc = 2'b00; extop = 2'b00; aluctrl = 2'b00;
    case (state_q)
      S_IF: begin
        memr = 1'b1;
        if (mem_rdy) begin
          irwr    = 1'b1;
          pcwr    = 1'b1;
          state_d = S_ID;
        end else if (tmo) begin
          merr = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ID: begin
        op_d = OpCode;
        fn_d = funct;
        if (OpCode == OP_J) begin
          pcwr    = 1'b1;
          pcsrc   = 2'b10;
          state_d = S_IF;
        end else if (id_legal) begin
          state_d = S_EXE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          ill_d   = 1'b1;
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end
      end
      S_EXE: begin
        state_d = S_WB;
        case (op_q)
          OP_R:   aluctrl = (fn_q == FN_SUBU) ? 2'b01 : 2'b00;
          OP_ORI: begin alusrc = 1'b1; extop = 2'b01; aluctrl = 2'b10; end
          OP_LUI: begin alusrc = 1'b1; extop = 2'b10; aluctrl = 2'b10; end
          OP_LW, OP_SW: begin alusrc = 1'b1; state_d = S_MEM; end
          OP_BEQ: begin
            aluctrl = 2'b01;
            pcwr    = Zero;
            pcsrc   = 2'b01;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        memr = (op_q == OP_LW);
        memw = (op_q == OP_SW);
        if (mem_rdy) begin
          state_d = (op_q == OP_LW) ? S_WB : S_IF;
        end else if (tmo) begin
          merr    = 1'b1;
          state_d = S_IF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        regw    = 1'b1;
        regdst  = (op_q != OP_R);
        mem2r   = (op_q == OP_LW);
        state_d = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Everything is held at zero while reset is asserted, so an aborted access never strobes.
  assign PCWr    = rst & pcwr;
  assign PCSrc   = rst ? pcsrc : 2'b00;
  assign IRWr    = rst & irwr;
  assign IorD    = rst & iord;
  assign MemR    = rst & memr;
  assign MemW    = rst & memw;
  assign Mem2R   = rst & mem2r;
  assign RegDst  = rst & regdst;
  assign RegW    = rst & regw;
  assign Alusrc  = rst & alusrc;
  assign ExtOp   = rst ? extop : 2'b00;
  assign Aluctrl = rst ? aluctrl : 2'b00;
  assign state   = rst ? 3'(state_q) : 3'd0;
  assign mem_err = rst & merr;
  assign illegal = rst & ill_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction table, randomized instruction stream, and
// hand-written timeout / reset / illegal-opcode sequences against an instruction-level reference model.
module tb_multi_cycle_ctrl;
  localparam int TMO = 4;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011;

  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] OpCode = '0, funct = '0;
  logic Zero = 1'b0, mem_rdy = 1'b0;
  logic PCWr, IRWr, IorD, MemR, MemW, Mem2R, RegDst, RegW, Alusrc, mem_err, illegal;
  logic [1:0] PCSrc, ExtOp, Aluctrl;
  logic [2:0] state;

  multi_cycle_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .Zero(Zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .IorD(IorD), .MemR(MemR), .MemW(MemW),
    .Mem2R(Mem2R), .RegDst(RegDst), .RegW(RegW), .Alusrc(Alusrc), .ExtOp(ExtOp),
    .Aluctrl(Aluctrl), .state(state), .mem_err(mem_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: what each instruction does, not how the FSM encodes it.
  typedef struct {
    bit legal, is_j, is_beq, uses_mem, is_lw, has_wb, alusrc, regdst;
    logic [1:0] alu, ext;
  } info_t;

  function automatic info_t info(input logic [5:0] op, input logic [5:0] fn);
    info_t i;
    i = '{default: 0};
    case (op)
      OP_R: begin
        if (fn == FN_ADDU) begin i.legal = 1; i.has_wb = 1; i.alu = 2'd0; end
        if (fn == FN_SUBU) begin i.legal = 1; i.has_wb = 1; i.alu = 2'd1; end
      end
      OP_ORI: begin i.legal = 1; i.has_wb = 1; i.alusrc = 1; i.ext = 2'd1; i.alu = 2'd2; i.regdst = 1; end
      OP_LUI: begin i.legal = 1; i.has_wb = 1; i.alusrc = 1; i.ext = 2'd2; i.alu = 2'd2; i.regdst = 1; end
      OP_LW:  begin i.legal = 1; i.uses_mem = 1; i.is_lw = 1; i.has_wb = 1; i.alusrc = 1; i.regdst = 1; end
      OP_SW:  begin i.legal = 1; i.uses_mem = 1; i.alusrc = 1; end
      OP_BEQ: begin i.legal = 1; i.is_beq = 1; i.alu = 2'd1; end
      OP_J:   begin i.legal = 1; i.is_j = 1; end
      default: ;
    endcase
    return i;
  endfunction

  // Runs one instruction from its first IF cycle, checking every cycle. w_mem >= TMO forces a MEM timeout.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                           input int w_if, input int w_mem,
                           output int lat, output logic [1:0] alu_seen, output logic rd_seen);
    info_t i;
    bit rdy, tmo;
    i = info(op, fn);
    lat = 0; alu_seen = 2'bxx; rd_seen = 1'bx;
    OpCode = op; funct = fn; Zero = zero;
    for (int k = 0; k <= w_if; k++) begin
      rdy = (k == w_if);
      mem_rdy = rdy;
      @(negedge clk);
      chk("if.state", state, 0);   chk("if.memr", MemR, 1);  chk("if.iord", IorD, 0);
      chk("if.irwr", IRWr, rdy);   chk("if.pcwr", PCWr, rdy); chk("if.regw", RegW, 0);
      chk("if.memw", MemW, 0);     chk("if.err", mem_err, 0);
      if (rdy) chk("if.pcsrc", PCSrc, 0);
      next_cycle(); lat++;
    end
    mem_rdy = 1'($urandom);
    @(negedge clk);
    chk("id.state", state, 1); chk("id.pcwr", PCWr, i.is_j); chk("id.irwr", IRWr, 0);
    chk("id.regw", RegW, 0);   chk("id.memr", MemR, 0);      chk("id.memw", MemW, 0);
    if (i.is_j) chk("id.pcsrc", PCSrc, 2);
    next_cycle(); lat++;
    if (i.is_j || !i.legal) return;
    OpCode = 6'($urandom); funct = 6'($urandom);   // IR may move on: EXE must use the latched copy
    @(negedge clk);
    alu_seen = Aluctrl;
    chk("exe.state", state, 2); chk("exe.alusrc", Alusrc, i.alusrc); chk("exe.alu", Aluctrl, i.alu);
    if (i.alusrc) chk("exe.ext", ExtOp, i.ext);
    chk("exe.pcwr", PCWr, i.is_beq && zero); chk("exe.regw", RegW, 0); chk("exe.memw", MemW, 0);
    if (i.is_beq) chk("exe.pcsrc", PCSrc, 1);
    next_cycle(); lat++;
    if (i.is_beq) return;
    if (i.uses_mem) begin
      for (int k = 0; k <= w_mem; k++) begin
        rdy = (k == w_mem);
        tmo = !rdy && (k == TMO - 1);
        mem_rdy = rdy;
        @(negedge clk);
        chk("mem.state", state, 3); chk("mem.iord", IorD, 1); chk("mem.pcwr", PCWr, 0);
        chk("mem.regw", RegW, 0);   chk("mem.err", mem_err, tmo);
        if (!tmo) begin chk("mem.memr", MemR, i.is_lw); chk("mem.memw", MemW, !i.is_lw); end
        next_cycle(); lat++;
        if (tmo) return;
      end
    end
    if (i.has_wb) begin
      mem_rdy = 1'($urandom);
      @(negedge clk);
      rd_seen = RegDst;
      chk("wb.state", state, 4); chk("wb.regw", RegW, 1); chk("wb.regdst", RegDst, i.regdst);
      chk("wb.mem2r", Mem2R, i.is_lw); chk("wb.pcwr", PCWr, 0); chk("wb.memw", MemW, 0);
      next_cycle(); lat++;
    end
  endtask

  typedef struct {
    logic [5:0] op, fn;
    logic       zero;
    int         lat;
    logic [1:0] alu;
    logic       rd;
  } vec_t;

  localparam logic [5:0] OP_LIST [8] = '{OP_R, OP_R, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
  localparam logic [5:0] FN_LIST [8] = '{FN_ADDU, FN_SUBU, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

  initial begin
    vec_t vecs[$];
    int lat;
    logic [1:0] alu;
    logic rd;

    // alu/rd of 2'bxx / 1'bx mean the stage is not visited (compared with !== as well)
    vecs.push_back('{OP_R,   FN_ADDU, 1'b0, 4, 2'd0,  1'b0});
    vecs.push_back('{OP_R,   FN_SUBU, 1'b0, 4, 2'd1,  1'b0});
    vecs.push_back('{OP_ORI, 6'd0,    1'b0, 4, 2'd2,  1'b1});
    vecs.push_back('{OP_LUI, 6'd5,    1'b0, 4, 2'd2,  1'b1});
    vecs.push_back('{OP_LW,  6'd0,    1'b0, 5, 2'd0,  1'b1});
    vecs.push_back('{OP_SW,  6'd0,    1'b0, 4, 2'd0,  1'bx});
    vecs.push_back('{OP_BEQ, 6'd0,    1'b1, 3, 2'd1,  1'bx});
    vecs.push_back('{OP_BEQ, 6'd0,    1'b0, 3, 2'd1,  1'bx});
    vecs.push_back('{OP_J,   6'd0,    1'b0, 2, 2'bxx, 1'bx});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{OP_BAD, 6'd0,    1'b0, 2, 2'bxx, 1'bx});
    vecs.push_back('{OP_R,   6'd0,    1'b0, 2, 2'bxx, 1'bx});
`endif

    // reset: everything forced low while rst is asserted, even with memory ready
    rst = 1'b0; mem_rdy = 1'b1; OpCode = OP_J;
    @(negedge clk);
    chk("rst.state", state, 0); chk("rst.pcwr", PCWr, 0); chk("rst.irwr", IRWr, 0);
    chk("rst.memr", MemR, 0);   chk("rst.regw", RegW, 0); chk("rst.ill", illegal, 0);
    chk("rst.err", mem_err, 0);
    next_cycle();
    rst = 1'b1;

    // IF timeout twice in a row: the counter restarts on re-entry
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < TMO; k++) begin
        mem_rdy = 1'b0;
        @(negedge clk);
        chk("ift.state", state, 0); chk("ift.irwr", IRWr, 0); chk("ift.pcwr", PCWr, 0);
        chk("ift.err", mem_err, k == TMO - 1);
        next_cycle();
      end
    end

    foreach (vecs[v]) begin
      run_instr(vecs[v].op, vecs[v].fn, vecs[v].zero, 0, 0, lat, alu, rd);
      chk($sformatf("tbl%0d.lat", v), 8'(lat), 8'(vecs[v].lat));
      chk($sformatf("tbl%0d.alu", v), {6'd0, alu}, {6'd0, vecs[v].alu});
      chk($sformatf("tbl%0d.rd", v), {7'd0, rd}, {7'd0, vecs[v].rd});
    end

    // lw with 3 wait cycles in MEM (no error), then ready exactly on the timeout cycle
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3, lat, alu, rd);
    chk("lw3.lat", 8'(lat), 8);
    run_instr(OP_SW, 6'd0, 1'b0, TMO - 1, TMO - 1, lat, alu, rd);
    chk("swedge.lat", 8'(lat), 8'(4 + 2 * (TMO - 1)));
    // lw MEM timeout: abort back to IF after TMO cycles in MEM
    run_instr(OP_LW, 6'd0, 1'b0, 0, TMO, lat, alu, rd);
    chk("lwtmo.lat", 8'(lat), 8'(3 + TMO));

    // reset during sw MEM
    OpCode = OP_SW; funct = 6'd0; mem_rdy = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    mem_rdy = 1'b0;
    @(negedge clk);
    chk("swr.state", state, 3); chk("swr.memw", MemW, 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("swr.memw0", MemW, 0); chk("swr.pcwr0", PCWr, 0); chk("swr.regw0", RegW, 0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("swr.if", state, 0); chk("swr.ifmemr", MemR, 1);

    // randomized legal instruction stream
    for (int n = 0; n < 60; n++) begin
      int s;
      s = $urandom_range(0, 7);
      run_instr(OP_LIST[s], FN_LIST[s], 1'($urandom), $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO), lat, alu, rd);
    end

    // illegal opcode
    run_instr(OP_BAD, 6'd0, 1'b0, 0, 0, lat, alu, rd);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      mem_rdy = 1'b1;
      @(negedge clk);
      chk("halt.state", state, 5); chk("halt.ill", illegal, 1);
      chk("halt.strobes", {PCWr, IRWr, MemR, MemW, RegW}, 0);
      next_cycle();
    end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("halt.rst.state", state, 0); chk("halt.rst.ill", illegal, 0);
`else
    @(negedge clk);
    chk("nop.state", state, 0); chk("nop.ill", illegal, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
